wta_argmin_sequencer: RTL and testbench

Winner-takes-all disparity selector for the SGM pipeline. It accepts one aggregated cost vector per pixel, with NUM_DISP costs. It time-multiplexes a single argmin_8 instance over the vector, 8 costs per cycle, and keeps a running minimum. It emits the winning disparity and its cost over a valid/ready handshake to the disparity-map writer.

---
 rtl/sgm_pkg.sv | 14 +
 rtl/argmin_8.sv | 23 ++
 rtl/wta_argmin_sequencer.sv | 114 +++++++++++
 tb/tb_wta_argmin_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sgm_pkg.sv
// Shared SGM pipeline definitions: default cost/disparity sizing and the
// winner-takes-all sequencer state encoding.
package sgm_pkg;

  localparam int unsigned COST_W   = 7;
  localparam int unsigned MAX_DISP = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } wta_state_e;

endpackage

// File: rtl/argmin_8.sv
// Combinational argmin over eight unsigned costs; returns the minimum value
// and its local index.
module argmin_8 #(
  parameter int unsigned WIDTH = 7
) (
  input  logic [8*WIDTH-1:0] data,
  output logic [WIDTH-1:0]   min_value,
  output logic [2:0]         min_index
);

  // Strict compare along the chain, so equal costs resolve to the lower index.
  always_comb begin
    min_value = data[WIDTH-1:0];
    min_index = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (data[i*WIDTH +: WIDTH] < min_value) begin
        min_value = data[i*WIDTH +: WIDTH];
        min_index = 3'(i);
      end
    end
  end

endmodule

// File: rtl/wta_argmin_sequencer.sv
// Winner-takes-all disparity selector: scans a cost vector eight costs per
// cycle through one argmin_8 and hands the running minimum downstream.
module wta_argmin_sequencer
  import sgm_pkg::*;
#(
  parameter  int unsigned WIDTH    = COST_W,
  parameter  int unsigned NUM_DISP = MAX_DISP,
  localparam int unsigned IDX_W    = $clog2(NUM_DISP),
  localparam int unsigned NUM_GRP  = NUM_DISP / 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_DISP*WIDTH-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [IDX_W-1:0]          out_disp,
  output logic [WIDTH-1:0]          out_cost,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int unsigned GRP_W = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;

  if ((NUM_DISP % 8) != 0 || NUM_DISP < 8) begin : g_bad_num_disp
    $error("wta_argmin_sequencer: NUM_DISP must be a multiple of 8 and >= 8");
  end

  wta_state_e                state_q;
  logic [NUM_DISP*WIDTH-1:0] vec_q;
  logic [GRP_W-1:0]          grp_q;
  logic [WIDTH-1:0]          run_val_q;
  logic [IDX_W-1:0]          run_idx_q;
  logic [IDX_W-1:0]          out_disp_q;
  logic [WIDTH-1:0]          out_cost_q;
  logic                      out_valid_q;
  logic                      busy_q;

  logic [8*WIDTH-1:0] grp_data;
  logic [WIDTH-1:0]   cand_val;
  logic [2:0]         local_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic               take;
  logic [WIDTH-1:0]   run_val_d;
  logic [IDX_W-1:0]   run_idx_d;
  logic               last_grp;

  assign grp_data = vec_q[int'(grp_q)*8*WIDTH +: 8*WIDTH];

  argmin_8 #(.WIDTH(WIDTH)) u_argmin (
    .data      (grp_data),
    .min_value (cand_val),
    .min_index (local_idx)
  );

  // Single-group builds drop the (always zero) group bit from the index.
  assign cand_idx  = IDX_W'({grp_q, local_idx});
  assign take      = (grp_q == '0) || (cand_val < run_val_q);
  assign run_val_d = take ? cand_val : run_val_q;
  assign run_idx_d = take ? cand_idx : run_idx_q;
  assign last_grp  = (grp_q == GRP_W'(NUM_GRP - 1));

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_disp  = out_disp_q;
  assign out_cost  = out_cost_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      grp_q       <= '0;
      run_val_q   <= '0;
      run_idx_q   <= '0;
      out_disp_q  <= '0;
      out_cost_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            vec_q   <= in_data;
            grp_q   <= '0;
            state_q <= SCAN;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          run_val_q <= run_val_d;
          run_idx_q <= run_idx_d;
          if (last_grp) begin
            out_disp_q  <= run_idx_d;
            out_cost_q  <= run_val_d;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else begin
            grp_q <= grp_q + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wta_argmin_sequencer.sv
// Self-checking bench for wta_argmin_sequencer (8-bit costs, 64 disparities)
// with a scoreboard of expected minima popped on each output transfer.
module tb_wta_argmin_sequencer;

  localparam int unsigned W  = 8;
  localparam int unsigned ND = 64;
  localparam int unsigned NG = ND / 8;
  localparam int unsigned IW = 6;

  typedef struct {
    logic [ND*W-1:0] vec;
    int unsigned     minv;
    int unsigned     grp;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [ND*W-1:0] in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IW-1:0]   out_disp;
  logic [W-1:0]    out_cost;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            busy;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  exp_t        sb[$];
  logic        stream_mode = 1'b0;
  logic        have_last = 1'b0;
  int unsigned last_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wta_argmin_sequencer #(.WIDTH(W), .NUM_DISP(ND)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_disp  (out_disp),
    .out_cost  (out_cost),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [ND*W-1:0] v);
    exp_t e;
    e.vec  = v;
    e.minv = 32'hFFFF_FFFF;
    e.grp  = 0;
    for (int unsigned d = 0; d < ND; d++) begin
      if (int'(v[d*W +: W]) < int'(e.minv) || e.minv == 32'hFFFF_FFFF) begin
        if (e.minv == 32'hFFFF_FFFF || 32'(v[d*W +: W]) < e.minv) begin
          e.minv = 32'(v[d*W +: W]);
          e.grp  = d / 8;
        end
      end
    end
    return e;
  endfunction

  function automatic logic [ND*W-1:0] rand_vec(input int unsigned lo);
    logic [ND*W-1:0] v;
    for (int unsigned d = 0; d < ND; d++) v[d*W +: W] = W'($urandom_range(lo, 255));
    return v;
  endfunction

  task automatic send(input logic [ND*W-1:0] v);
    int unsigned n = 0;
    in_data  = v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 1, 0);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(model(v));
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int unsigned n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) check("valid_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (out_valid) check("idle_timeout", 1, 0);
  endtask

  // Scoreboard: any index is accepted if its cost is the minimum and it lies
  // in the earliest group holding that minimum.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        check("cost", 32'(out_cost), e.minv);
        check("cost_at_disp", 32'(e.vec[int'(out_disp)*W +: W]), e.minv);
        check("disp_grp", 32'(out_disp >> 3), e.grp);
      end
      if (stream_mode) begin
        if (have_last) check("spacing", cyc - last_cyc, NG + 2);
        have_last = 1'b1;
        last_cyc  = cyc;
      end
    end
  end

  initial begin
    logic [ND*W-1:0] v;
    int unsigned     n;
    int unsigned     bad;
    logic [IW-1:0]   d0;
    logic [W-1:0]    c0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_disp", 32'(out_disp), 0);
    check("rst_out_cost", 32'(out_cost), 0);
    rst_n = 1'b1;
    #1 check("idle_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;

    // Single clear minimum, plus accept-to-valid latency.
    for (int unsigned d = 0; d < ND; d++) v[d*W +: W] = W'(100 + d);
    v[37*W +: W] = 8'd5;
    send(v);
    wait_valid(n);
    check("latency", n, NG);
    check("t1_disp", 32'(out_disp), 37);
    check("t1_cost", 32'(out_cost), 5);
    wait_idle();

    // All equal: group 0 must win.
    for (int unsigned d = 0; d < ND; d++) v[d*W +: W] = 8'd100;
    send(v);
    wait_valid(n);
    check("t2_cost", 32'(out_cost), 100);
    check("t2_disp_lt8", 32'(out_disp < 8), 1);
    wait_idle();

    // Tie across groups keeps the earlier one.
    for (int unsigned d = 0; d < ND; d++) v[d*W +: W] = 8'd127;
    v[3*W +: W]  = 8'd9;
    v[59*W +: W] = 8'd9;
    send(v);
    wait_valid(n);
    check("t3_disp", 32'(out_disp), 3);
    check("t3_cost", 32'(out_cost), 9);
    wait_idle();

    // Back-pressure.
    out_ready = 1'b0;
    send(rand_vec(0));
    wait_valid(n);
    d0  = out_disp;
    c0  = out_cost;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_disp !== d0 || out_cost !== c0 ||
          in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("bp_stable", bad, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_drop", 32'(out_valid), 0);
    check("bp_in_ready", 32'(in_ready), 1);

    // Reset in the middle of a scan (group 4).
    send(rand_vec(0));
    repeat (4) @(posedge clk);
    #1;
    check("scan_busy", 32'(busy), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    check("mid_rst_busy", 32'(busy), 0);
    sb.delete();
    v = rand_vec(1);
    v[63*W +: W] = 8'd0;
    send(v);
    wait_valid(n);
    check("t5_disp", 32'(out_disp), 63);
    check("t5_cost", 32'(out_cost), 0);
    wait_idle();

    // Streaming with exact spacing.
    stream_mode = 1'b1;
    have_last   = 1'b0;
    for (int i = 0; i < 100; i++) send(rand_vec(0));
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    check("sb_drained", sb.size(), 0);
    stream_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
